complex_div_fu: RTL and testbench
=================================

# complex_div_fu

Parametrised iterative divide/modulo functional unit for the complex issue port; successor to the fixed-latency complex FU. It accepts one DIV/MOD/DIVU/MODU micro-op from the complex issue queue and computes quotient or remainder with a shift-subtract datapath retiring `BITS_PER_CYCLE` quotient bits per cycle. It holds the result until the writeback arbiter accepts it, and discards in-flight work on pipeline flush.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width; must be a multiple of `BITS_PER_CYCLE`.
- `BITS_PER_CYCLE`, 1: quotient bits per iteration; legal values 1, 2, 4.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `issued_info`, in, `complex_issue_queue_issued_info_t`: issued micro-op (rob index, preg rd/rj/rk, gen/spec op type).
- `issue_valid`, in, 1: issue request.
- `fu_ready`, out, 1: unit can accept an issue this cycle.
- `flush`, in, 1: kill any op in flight; synchronous.
- `prf_read_rj_index`, `prf_read_rk_index`, out, `PREG_INDEX_WIDTH`: combinational copies of `issued_info.issued_preg_rj/rk`.
- `rj_val`, `rk_val`, in, `DATA_WIDTH`: operands, valid in the issue cycle.
- `result`, out, `DATA_WIDTH`: writeback data.
- `wb_rd_index`, out, `PREG_INDEX_WIDTH`: destination preg.
- `wb_rob_entry_index`, out, `ROB_ENTRY_INDEX_WIDTH`: ROB tag.
- `result_valid`, out, 1: result presented.
- `wb_ready`, in, 1: writeback accepts the result this cycle.

## Operation
- States: IDLE, CALC, FIX, DONE. `fu_ready = (state == IDLE)`.
- **Accept:** an op is accepted when `issue_valid && fu_ready && !flush`. On accept, latch the tag, rd, op type, sign mode, |rj| and |rk| (magnitudes only for signed ops), and the operand signs. Clear the partial remainder and load the iteration counter with `DATA_WIDTH/BITS_PER_CYCLE`.
- **Routing on accept:**
  - Unsupported op (not `GENERAL_OPTYPE_3R` with `_3R_DIV/_3R_MOD/_3R_DIVU/_3R_MODU`): go to FIX and produce result 0.
  - Otherwise: go to CALC.
- **CALC:** each cycle performs `BITS_PER_CYCLE` restoring steps. Each step shifts the next dividend MSB into the remainder, does a trial subtract of the divisor, and shifts the not-borrow bit into the quotient. Decrement the counter; when it reaches 0, go to FIX.
- **FIX (one cycle), register `result`:**
  - Signed ops: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Overflow: `DIV(MIN,-1)` = MIN, `MOD(MIN,-1)` = 0.
  - Divisor zero, all ops: quotient = all-ones, remainder = rj_val (original, unsigned bit pattern).
  - Go to DONE.
- **DONE:** `result_valid` = 1, with outputs stable. On `wb_ready`, go to IDLE. Otherwise hold, with all outputs unchanged.
- **Flush:** highest priority in every state. The next state is IDLE, `result_valid` drops the next cycle, and the result is never written back. An issue arriving in the same cycle as a flush is not accepted.

## Timing
- Reset values: state IDLE, `fu_ready` = 1, `result_valid` = 0, `result` = 0, `wb_rd_index` = 0, `wb_rob_entry_index` = 0. Internal registers are cleared.
- Latency (issue edge to first `result_valid` cycle) for a normal op: `DATA_WIDTH/BITS_PER_CYCLE + 2`. That is 34 at 32/1 and 18 at 32/2.
- Latency for an unsupported op: 2.
- Throughput: one op at a time. After the DONE handshake, the state is IDLE the next cycle, so the earliest re-issue is one cycle after `wb_ready`.
- Reset asserted mid-operation: immediate return to reset values; no output is generated.

## Configuration
- `COMPLEX_DIV_ZERO_FASTPATH_EN`:
  - Defined: an accepted op with `rk_val == 0` bypasses CALC and goes IDLE→FIX→DONE, with latency 2.
  - Undefined: a divisor-zero op runs full CALC latency.
  - Result values are identical in both cases; only latency differs.

## Test plan
- DIV 100 / 7 (32/1): `result_valid` rises exactly 34 cycles after issue with `result` = 14. Rerun as MOD: `result` = 2.
- Signed DIV -7 / 2 → 0xFFFFFFFD. MOD -7 / 2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC. MODU → 1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, MOD → 0. DIV 5 / 0 → 0xFFFFFFFF, MOD 5 / 0 → 5. Check latency 2 with the fast-path macro and 34 without it.
- Hold `wb_ready` = 0 for 5 cycles after `result_valid`: `result`, tag and rd stay stable and `fu_ready` stays 0. On `wb_ready` = 1, IDLE follows the next cycle and a new issue is accepted.
- Assert `flush` in CALC cycle 10, with `issue_valid` high in the same cycle: no `result_valid` ever appears for either op, and `fu_ready` = 1 the next cycle.
- `BITS_PER_CYCLE` = 4 build: DIV 1000 / 3 → 333 at latency 10; random signed/unsigned operands checked against a reference model.

Source files
------------

// File: rtl/complex_div_fu_if.sv
// Shared issue/writeback types and the complex_div_fu port bundle.
// slave = the functional unit, master = issue queue / writeback side.
package complex_issue_pkg;
  localparam int PREG_INDEX_WIDTH      = 6;
  localparam int ROB_ENTRY_INDEX_WIDTH = 6;

  localparam logic [2:0] GENERAL_OPTYPE_ALU = 3'd0;
  localparam logic [2:0] GENERAL_OPTYPE_3R  = 3'd1;

  localparam logic [3:0] _3R_MUL  = 4'd0;
  localparam logic [3:0] _3R_DIV  = 4'd4;
  localparam logic [3:0] _3R_MOD  = 4'd5;
  localparam logic [3:0] _3R_DIVU = 4'd6;
  localparam logic [3:0] _3R_MODU = 4'd7;

  typedef struct packed {
    logic [ROB_ENTRY_INDEX_WIDTH-1:0] rob_entry_index;
    logic [PREG_INDEX_WIDTH-1:0]      issued_preg_rd;
    logic [PREG_INDEX_WIDTH-1:0]      issued_preg_rj;
    logic [PREG_INDEX_WIDTH-1:0]      issued_preg_rk;
    logic [2:0]                       gen_op_type;
    logic [3:0]                       spec_op_type;
  } complex_issue_queue_issued_info_t;
endpackage

interface complex_div_fu_if #(
  parameter int DATA_WIDTH = 32
);
  import complex_issue_pkg::*;

  complex_issue_queue_issued_info_t   issued_info;
  logic                               issue_valid;
  logic                               fu_ready;
  logic                               flush;
  logic [PREG_INDEX_WIDTH-1:0]        prf_read_rj_index;
  logic [PREG_INDEX_WIDTH-1:0]        prf_read_rk_index;
  logic [DATA_WIDTH-1:0]              rj_val;
  logic [DATA_WIDTH-1:0]              rk_val;
  logic [DATA_WIDTH-1:0]              result;
  logic [PREG_INDEX_WIDTH-1:0]        wb_rd_index;
  logic [ROB_ENTRY_INDEX_WIDTH-1:0]   wb_rob_entry_index;
  logic                               result_valid;
  logic                               wb_ready;

  modport slave (
    input  issued_info, issue_valid, flush, rj_val, rk_val, wb_ready,
    output fu_ready, prf_read_rj_index, prf_read_rk_index, result,
           wb_rd_index, wb_rob_entry_index, result_valid
  );

  modport master (
    output issued_info, issue_valid, flush, rj_val, rk_val, wb_ready,
    input  fu_ready, prf_read_rj_index, prf_read_rk_index, result,
           wb_rd_index, wb_rob_entry_index, result_valid
  );
endinterface

// File: rtl/complex_div_fu.sv
// Iterative restoring DIV/MOD/DIVU/MODU unit; latency DATA_WIDTH/BITS_PER_CYCLE+2, 2 for unsupported ops.
// Result held in DONE until wb_ready; fu_ready only in IDLE; flush wins everywhere.
// COMPLEX_DIV_ZERO_FASTPATH_EN: zero divisors skip CALC (latency 2, same result).
module complex_div_fu
  import complex_issue_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic             clk,
  input logic             rst_n,
  complex_div_fu_if.slave fu
);
  localparam int ITER  = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]                       state;
  logic [CNT_W-1:0]                 cnt;
  logic [DATA_WIDTH-1:0]            quo_q, rem_q, div_q, rj_raw_q, result_q;
  logic [PREG_INDEX_WIDTH-1:0]      rd_q;
  logic [ROB_ENTRY_INDEX_WIDTH-1:0] rob_q;
  logic                             is_mod_q, unsup_q, rj_neg_q, rk_neg_q;

  complex_issue_queue_issued_info_t info;
  logic                  op_div, op_mod, op_divu, op_modu, supported, is_signed, rj_neg, rk_neg;
  logic [DATA_WIDTH-1:0] rj_abs, rk_abs;

  assign info = fu.issued_info;

  always_comb begin
    op_div    = (info.spec_op_type == _3R_DIV);
    op_mod    = (info.spec_op_type == _3R_MOD);
    op_divu   = (info.spec_op_type == _3R_DIVU);
    op_modu   = (info.spec_op_type == _3R_MODU);
    supported = (info.gen_op_type == GENERAL_OPTYPE_3R) && (op_div || op_mod || op_divu || op_modu);
    is_signed = op_div || op_mod;
    rj_neg    = is_signed && fu.rj_val[DATA_WIDTH-1];
    rk_neg    = is_signed && fu.rk_val[DATA_WIDTH-1];
    rj_abs    = rj_neg ? -fu.rj_val : fu.rj_val;
    rk_abs    = rk_neg ? -fu.rk_val : fu.rk_val;
  end

  // Dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
  logic [DATA_WIDTH-1:0] quo_n, rem_n;
  logic [DATA_WIDTH:0]   shifted, diff;

  always_comb begin
    quo_n   = quo_q;
    rem_n   = rem_q;
    shifted = '0;
    diff    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {rem_n, quo_n[DATA_WIDTH-1]};
      diff    = shifted - {1'b0, div_q};
      rem_n   = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
      quo_n   = {quo_n[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    end
  end

  // MIN/-1 needs no special case: |MIN| = 2^(W-1) unsigned, whose negation wraps back to MIN.
  logic [DATA_WIDTH-1:0] quo_fix, rem_fix, fix_val;

  always_comb begin
    quo_fix = (rj_neg_q ^ rk_neg_q) ? -quo_q : quo_q;
    rem_fix = rj_neg_q ? -rem_q : rem_q;
    if (unsup_q)
      fix_val = '0;
    else if (div_q == '0)
      fix_val = is_mod_q ? rj_raw_q : '1;
    else
      fix_val = is_mod_q ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      rj_raw_q <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rob_q    <= '0;
      is_mod_q <= 1'b0;
      unsup_q  <= 1'b0;
      rj_neg_q <= 1'b0;
      rk_neg_q <= 1'b0;
    end else if (fu.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fu.issue_valid) begin
            rob_q    <= info.rob_entry_index;
            rd_q     <= info.issued_preg_rd;
            is_mod_q <= op_mod || op_modu;
            unsup_q  <= !supported;
            rj_neg_q <= rj_neg;
            rk_neg_q <= rk_neg;
            rj_raw_q <= fu.rj_val;
            quo_q    <= rj_abs;
            div_q    <= rk_abs;
            rem_q    <= '0;
            cnt      <= ITER_CNT;
            if (!supported)
              state <= FIX;
`ifdef COMPLEX_DIV_ZERO_FASTPATH_EN
            else if (fu.rk_val == '0)
              state <= FIX;
`endif
            else
              state <= CALC;
          end
        end
        CALC: begin
          quo_q <= quo_n;
          rem_q <= rem_n;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= FIX;
        end
        FIX: begin
          result_q <= fix_val;
          state    <= DONE;
        end
        DONE: begin
          if (fu.wb_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fu.fu_ready           = (state == IDLE);
  assign fu.result_valid       = (state == DONE);
  assign fu.prf_read_rj_index  = info.issued_preg_rj;
  assign fu.prf_read_rk_index  = info.issued_preg_rk;
  assign fu.result             = result_q;
  assign fu.wb_rd_index        = rd_q;
  assign fu.wb_rob_entry_index = rob_q;
endmodule

// File: tb/tb_complex_div_fu.sv
// Scoreboard bench for complex_div_fu: a 1-bit/cycle and a 4-bit/cycle instance share operand/flush stimulus.
module tb_complex_div_fu;
  import complex_issue_pkg::*;

`ifdef COMPLEX_DIV_ZERO_FASTPATH_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  complex_issue_queue_issued_info_t info;
  logic [31:0] rj, rk;
  logic        flush, iv1, iv4, wr1, wr4;

  complex_div_fu_if #(.DATA_WIDTH(32)) if1 ();
  complex_div_fu_if #(.DATA_WIDTH(32)) if4 ();

  assign if1.issued_info = info;
  assign if1.rj_val      = rj;
  assign if1.rk_val      = rk;
  assign if1.flush       = flush;
  assign if1.issue_valid = iv1;
  assign if1.wb_ready    = wr1;
  assign if4.issued_info = info;
  assign if4.rj_val      = rj;
  assign if4.rk_val      = rk;
  assign if4.flush       = flush;
  assign if4.issue_valid = iv4;
  assign if4.wb_ready    = wr4;

  complex_div_fu #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .fu(if1));
  complex_div_fu #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .fu(if4));

  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  rd;
    logic [5:0]  rob;
  } exp_t;

  exp_t        q1[$], q4[$];
  exp_t        e1, e4;
  int          n_cmp = 0, n_bad = 0;
  logic [5:0]  tag = 6'd1;
  logic [5:0]  last_rd, last_rob;

  // Scoreboard consumers: compare on each writeback handshake, sampled mid-cycle.
  always begin
    @(negedge clk); #2;
    if (rst_n && !flush && if1.result_valid && wr1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL wb1_unexpected: result %h written back, none expected", if1.result);
      end else begin
        e1 = q1.pop_front();
        if ({if1.result, if1.wb_rd_index, if1.wb_rob_entry_index} !== e1) begin
          n_bad++;
          $display("FAIL wb1_data: got res=%h rd=%0d rob=%0d, want res=%h rd=%0d rob=%0d",
                   if1.result, if1.wb_rd_index, if1.wb_rob_entry_index, e1.res, e1.rd, e1.rob);
        end
      end
    end
  end

  always begin
    @(negedge clk); #2;
    if (rst_n && !flush && if4.result_valid && wr4) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL wb4_unexpected: result %h written back, none expected", if4.result);
      end else begin
        e4 = q4.pop_front();
        if ({if4.result, if4.wb_rd_index, if4.wb_rob_entry_index} !== e4) begin
          n_bad++;
          $display("FAIL wb4_data: got res=%h rd=%0d rob=%0d, want res=%h rd=%0d rob=%0d",
                   if4.result, if4.wb_rd_index, if4.wb_rob_entry_index, e4.res, e4.rd, e4.rob);
        end
      end
    end
  end

  function automatic logic [31:0] ref_model(input logic [3:0] sp, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (sp)
      _3R_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      _3R_MOD:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      _3R_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      _3R_MODU: return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  // Drives one issue in the current cycle; caller is at a negedge.
  task automatic issue(input int u, input logic [2:0] gen, input logic [3:0] sp,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] ev, input bit push);
    info.rob_entry_index = tag;
    info.issued_preg_rd  = tag ^ 6'h2A;
    info.issued_preg_rj  = tag + 6'd1;
    info.issued_preg_rk  = tag + 6'd2;
    info.gen_op_type     = gen;
    info.spec_op_type    = sp;
    rj = a;
    rk = b;
    last_rd  = tag ^ 6'h2A;
    last_rob = tag;
    if (u == 1) iv1 = 1'b1; else iv4 = 1'b1;
    if (push) begin
      if (u == 1) q1.push_back('{ev, tag ^ 6'h2A, tag});
      else        q4.push_back('{ev, tag ^ 6'h2A, tag});
    end
    tag = tag + 6'd1;
  endtask

  task automatic wait_valid(input int u, output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin iv1 = 1'b0; iv4 = 1'b0; end
      if (((u == 1) ? if1.result_valid : if4.result_valid) === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic ack(input int u);
    if (u == 1) wr1 = 1'b1; else wr4 = 1'b1;
    @(negedge clk);
    wr1 = 1'b0;
    wr4 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if1.fu_ready, if1.result_valid, if1.result, if1.wb_rd_index, if1.wb_rob_entry_index} !== {1'b1, 1'b0, 32'h0, 6'h0, 6'h0}) begin
      n_bad++;
      $display("FAIL reset_dut1: ready=%b valid=%b res=%h rd=%0d rob=%0d, want 1 0 0 0 0",
               if1.fu_ready, if1.result_valid, if1.result, if1.wb_rd_index, if1.wb_rob_entry_index);
    end
    n_cmp++;
    if ({if4.fu_ready, if4.result_valid, if4.result} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_dut4: ready=%b valid=%b res=%h, want 1 0 0", if4.fu_ready, if4.result_valid, if4.result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    issue(1, GENERAL_OPTYPE_3R, _3R_DIV, 32'd100, 32'd7, 32'd14, 1'b1);
    #1;
    n_cmp++;
    if ({if1.prf_read_rj_index, if1.prf_read_rk_index} !== {info.issued_preg_rj, info.issued_preg_rk}) begin
      n_bad++;
      $display("FAIL prf_index: got %0d/%0d want %0d/%0d", if1.prf_read_rj_index, if1.prf_read_rk_index,
               info.issued_preg_rj, info.issued_preg_rk);
    end
    wait_valid(1, lat);
    n_cmp++;
    if (lat !== 34) begin n_bad++; $display("FAIL div_latency: got %0d want 34", lat); end
    ack(1);
    issue(1, GENERAL_OPTYPE_3R, _3R_MOD, 32'd100, 32'd7, 32'd2, 1'b1);
    wait_valid(1, lat);
    n_cmp++;
    if (lat !== 34) begin n_bad++; $display("FAIL mod_latency: got %0d want 34", lat); end
    ack(1);
  endtask

  task automatic test_signed_special;
    logic [3:0]  sp_t [10];
    logic [31:0] a_t [10], b_t [10], e_t [10];
    int          lat, want;
    sp_t = '{_3R_DIV, _3R_MOD, _3R_DIVU, _3R_MODU, _3R_DIV, _3R_MOD, _3R_DIV, _3R_MOD, _3R_DIVU, _3R_MOD};
    a_t  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
             32'd5, 32'd5, 32'd9, 32'hFFFF_FFFB};
    b_t  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    e_t  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1, 32'h8000_0000, 32'd0,
             32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    for (int i = 0; i < 10; i++) begin
      issue(1, GENERAL_OPTYPE_3R, sp_t[i], a_t[i], b_t[i], e_t[i], 1'b1);
      wait_valid(1, lat);
      want = (b_t[i] == 32'd0 && FAST_ZERO) ? 2 : 34;
      n_cmp++;
      if (lat !== want) begin n_bad++; $display("FAIL special_latency[%0d]: got %0d want %0d", i, lat, want); end
      ack(1);
    end
  endtask

  task automatic test_unsupported;
    int lat;
    issue(1, GENERAL_OPTYPE_ALU, _3R_DIV, 32'd50, 32'd3, 32'd0, 1'b1);
    wait_valid(1, lat);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL unsup_gen_latency: got %0d want 2", lat); end
    ack(1);
    issue(1, GENERAL_OPTYPE_3R, _3R_MUL, 32'd6, 32'd7, 32'd0, 1'b1);
    wait_valid(1, lat);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL unsup_spec_latency: got %0d want 2", lat); end
    ack(1);
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [5:0] rd0, rob0;
    issue(1, GENERAL_OPTYPE_3R, _3R_DIV, 32'd1000, 32'd10, 32'd100, 1'b1);
    rd0  = last_rd;
    rob0 = last_rob;
    wait_valid(1, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({if1.result_valid, if1.fu_ready, if1.result, if1.wb_rd_index, if1.wb_rob_entry_index} !== {1'b1, 1'b0, 32'd100, rd0, rob0}) begin
        n_bad++;
        $display("FAIL hold[%0d]: valid=%b ready=%b res=%h rd=%0d rob=%0d, want 1 0 00000064 %0d %0d",
                 k, if1.result_valid, if1.fu_ready, if1.result, if1.wb_rd_index, if1.wb_rob_entry_index, rd0, rob0);
      end
    end
    ack(1);
    n_cmp++;
    if (if1.fu_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_ack: got %b want 1", if1.fu_ready); end
    issue(1, GENERAL_OPTYPE_3R, _3R_DIVU, 32'd81, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    iv1 = 1'b0;
    n_cmp++;
    if (if1.fu_ready !== 1'b0) begin n_bad++; $display("FAIL reissue_accept: fu_ready=%b want 0", if1.fu_ready); end
    wait_valid(1, lat);
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL reissue_latency: got %0d want 33", lat); end
    ack(1);
  endtask

  task automatic test_flush;
    int lat;
    bit seen;
    issue(1, GENERAL_OPTYPE_3R, _3R_DIV, 32'd12345, 32'd3, 32'd0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) iv1 = 1'b0;
    end
    flush = 1'b1;
    issue(1, GENERAL_OPTYPE_3R, _3R_DIVU, 32'd7, 32'd7, 32'd0, 1'b0);
    n_cmp++;
    if (if1.fu_ready !== 1'b0) begin n_bad++; $display("FAIL flush_calc_busy: fu_ready=%b want 0", if1.fu_ready); end
    @(negedge clk);
    flush = 1'b0;
    iv1   = 1'b0;
    n_cmp++;
    if (if1.fu_ready !== 1'b1) begin n_bad++; $display("FAIL flush_calc_ready: fu_ready=%b want 1", if1.fu_ready); end
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (if1.result_valid !== 1'b0 || if1.fu_ready !== 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_calc_quiet: activity after flush=%b want 0", seen); end

    flush = 1'b1;
    issue(1, GENERAL_OPTYPE_3R, _3R_DIV, 32'd9, 32'd3, 32'd0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    iv1   = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (if1.result_valid !== 1'b0 || if1.fu_ready !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_idle_issue: op accepted under flush=%b want 0", seen); end

    issue(1, GENERAL_OPTYPE_ALU, _3R_MUL, 32'd9, 32'd3, 32'd0, 1'b0);
    wait_valid(1, lat);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if ({if1.result_valid, if1.fu_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_done: valid=%b ready=%b want 0 1", if1.result_valid, if1.fu_ready);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    issue(1, GENERAL_OPTYPE_3R, _3R_DIVU, 32'd5000, 32'd7, 32'd0, 1'b0);
    @(negedge clk);
    iv1 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if1.fu_ready, if1.result_valid, if1.result} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_mid: ready=%b valid=%b res=%h want 1 0 0", if1.fu_ready, if1.result_valid, if1.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (if1.result_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_mid_quiet: result_valid seen=%b want 0", seen); end
  endtask

  task automatic test_radix4_random;
    int lat, want, u;
    logic [31:0] a, b;
    logic [3:0]  sp;
    issue(4, GENERAL_OPTYPE_3R, _3R_DIV, 32'd1000, 32'd3, 32'd333, 1'b1);
    wait_valid(4, lat);
    n_cmp++;
    if (lat !== 10) begin n_bad++; $display("FAIL r4_latency: got %0d want 10", lat); end
    ack(4);
    for (int i = 0; i < 32; i++) begin
      u = (i % 4 == 0) ? 1 : 4;
      case ($urandom_range(0, 3))
        0:       sp = _3R_DIV;
        1:       sp = _3R_MOD;
        2:       sp = _3R_DIVU;
        default: sp = _3R_MODU;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 15);
        4:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue(u, GENERAL_OPTYPE_3R, sp, a, b, ref_model(sp, a, b), 1'b1);
      wait_valid(u, lat);
      want = (b == 32'h0 && FAST_ZERO) ? 2 : (32 / u + 2);
      n_cmp++;
      if (lat !== want) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, want); end
      ack(u);
    end
  endtask

  initial begin
    info  = '0;
    rj    = '0;
    rk    = '0;
    flush = 1'b0;
    iv1   = 1'b0;
    iv4   = 1'b0;
    wr1   = 1'b0;
    wr4   = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_signed_special();
    test_unsupported();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_radix4_random();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q1.size() + q4.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expected results never written back, want 0", q1.size() + q4.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
